muldiv_seq: RTL and testbench

Iterative 16-bit unsigned multiply/divide sequencer for the ALU's arithmetic datapath. Replaces the combinational 16x16 array multiplier and divider on area-critical paths. Accepts one operation at a time over a valid/ready handshake. Runs one shift-add (multiply) or restoring-subtract (divide) step per clock and returns a 32-bit result over a second valid/ready handshake.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_seq_if.sv | 27 ++
 rtl/muldiv_step.sv | 30 +++
 rtl/muldiv_seq.sv | 123 ++++++++++++
 tb/tb_muldiv_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Wide enough for any supported WIDTH; users cast down to their operand width.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bus of the multiply/divide sequencer.
// Both channels transfer on a rising edge where valid and ready are both high;
// a producer holds valid and its payload stable until that edge, and ready may not depend on valid.
interface muldiv_seq_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               div0;
  logic               busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, div0, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, div0, busy
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring trial-subtract for divide.
// acc holds {upper, multiplier} for multiply and {remainder, quotient} for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    // rem_sh < 2*divisor, so bit WIDTH of the difference is set exactly when it went negative.
    diff   = rem_sh - {1'b0, operand};
    if (op == OP_MUL) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (diff[WIDTH]) begin
      acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer, one step per clock.
// Optional MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus,
  output state_t      fsm_state
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [2*WIDTH-1:0] acc, acc_nx, step_acc, acc_aligned;
  logic [WIDTH-1:0]   opnd, opnd_nx;
  logic               op_r, op_nx, div0_r, div0_nx;
  logic               early_done;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_r),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (step_acc)
  );

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] remain_mask;
  // After step cnt, the unconsumed multiplier bits sit in the low WIDTH-1-cnt bits.
  assign remain_mask = {WIDTH{1'b1}} >> (cnt + CNT_W'(1));
  assign early_done  = ((step_acc[WIDTH-1:0] & remain_mask) == '0);
  assign acc_aligned = step_acc >> (LAST - cnt);
`else
  assign early_done  = 1'b0;
  assign acc_aligned = step_acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_r   <= OP_MUL;
      div0_r <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      acc    <= acc_nx;
      opnd   <= opnd_nx;
      op_r   <= op_nx;
      div0_r <= div0_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    acc_nx   = acc;
    opnd_nx  = opnd;
    op_nx    = op_r;
    div0_nx  = div0_r;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          cnt_nx  = '0;
          op_nx   = bus.op;
          div0_nx = 1'b0;
          if (bus.op == OP_MUL) begin
            acc_nx   = {{WIDTH{1'b0}}, bus.b};
            opnd_nx  = bus.a;
            state_nx = MUL;
          end else if (bus.b == '0) begin
            // Divide by zero takes one pass through DIV so its result lands one edge after accept.
            acc_nx   = {bus.a, WIDTH'(DIV0_QUOTIENT)};
            opnd_nx  = bus.b;
            div0_nx  = 1'b1;
            state_nx = DIV;
          end else begin
            acc_nx   = {{WIDTH{1'b0}}, bus.a};
            opnd_nx  = bus.b;
            state_nx = DIV;
          end
        end
      end
      MUL: begin
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          acc_nx   = step_acc;
          state_nx = DONE;
        end else if (early_done) begin
          acc_nx   = acc_aligned;
          state_nx = DONE;
        end else begin
          acc_nx = step_acc;
        end
      end
      DIV: begin
        if (div0_r) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
          acc_nx = step_acc;
          if (cnt == LAST) state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = acc;
  assign bus.div0      = div0_r;
  assign fsm_state     = state;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed scoreboard bench for muldiv_seq; honours MULDIV_EARLY_OUT_EN for multiply latency.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 16;

  logic   clk;
  logic   rst;
  state_t fsm_state;
  int     cyc = 0;
  int     n_total = 0;
  int     n_pass = 0;

  logic [2*W:0] exp_q[$];   // {div0, result}
  int           lat_q[$];
  int           acc_q[$];

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int mul_lat(input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
`else
    return W;
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp_res, input logic exp_div0, input int lat);
    int t;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back({exp_div0, exp_res});
    lat_q.push_back(lat);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = $urandom_range(0, 16'hFFFF);
    bus.b = $urandom_range(0, 16'hFFFF);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic         prev_v;
    logic [2*W:0] e;
    int           l, s;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (bus.out_valid && !prev_v) begin
          if (lat_q.size() == 0) begin
            check("spurious_out_valid", 64'd1, 64'd0);
          end else begin
            l = lat_q.pop_front();
            s = acc_q.pop_front();
            check("latency", 64'(cyc - s), 64'(l));
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("result", 64'(bus.result), 64'(e[2*W-1:0]));
            check("div0", 64'(bus.div0), 64'(e[2*W]));
          end
        end
        prev_v = bus.out_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = OP_MUL;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_div0", 64'(bus.div0), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: op, a, b, {remainder,quotient} or product, div0, latency
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, mul_lat(16'hFFFF)); drain();
    issue(OP_DIV, 16'd1000, 16'd7,    32'h0006_008E, 1'b0, 16);                drain();
    issue(OP_DIV, 16'h1234, 16'h0000, 32'h1234_FFFF, 1'b1, 1);                 drain();
    issue(OP_MUL, 16'h1234, 16'h0003, 32'h0000_369C, 1'b0, mul_lat(16'h0003)); drain();
    issue(OP_MUL, 16'h0007, 16'h0000, 32'h0000_0000, 1'b0, mul_lat(16'h0000)); drain();
    issue(OP_MUL, 16'h8000, 16'h0002, 32'h0001_0000, 1'b0, mul_lat(16'h0002)); drain();
    issue(OP_MUL, 16'h00FF, 16'h8000, 32'h007F_8000, 1'b0, mul_lat(16'h8000)); drain();
    issue(OP_DIV, 16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0, 16);                drain();
    issue(OP_DIV, 16'd5,    16'd9,    32'h0005_0000, 1'b0, 16);                drain();
    issue(OP_DIV, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0, 16);                drain();
    issue(OP_DIV, 16'h0000, 16'h0000, 32'h0000_FFFF, 1'b1, 1);                 drain();

    // Backpressure: result must hold while out_ready is low; new requests are ignored
    bus.out_ready = 1'b0;
    issue(OP_MUL, 16'd3, 16'd5, 32'd15, 1'b0, mul_lat(16'd5));
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op = OP_DIV;
      bus.a  = $urandom_range(1, 16'hFFFF);
      bus.b  = 16'h0000;
      #1;
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_result", 64'(bus.result), 64'd15);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_release_busy", 64'(bus.busy), 64'd0);
    repeat (5) @(negedge clk);
    check("bp_no_queued_req", 64'(bus.busy), 64'd0);

    // Reset in the middle of a divide: the operation must vanish
    issue(OP_DIV, 16'd1000, 16'd7, 32'h0006_008E, 1'b0, 16);
    repeat (8) @(negedge clk);
    check("midop_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    void'(acc_q.pop_back());
    @(negedge clk);
    #1;
    check("midop_in_ready", 64'(bus.in_ready), 64'd1);
    check("midop_out_valid", 64'(bus.out_valid), 64'd0);
    check("midop_busy_after", 64'(bus.busy), 64'd0);
    check("midop_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midop_still_idle", 64'(fsm_state), 64'(IDLE));

    // Recovery after reset
    issue(OP_MUL, 16'h1234, 16'h0003, 32'h0000_369C, 1'b0, mul_lat(16'h0003)); drain();
    issue(OP_DIV, 16'd50000, 16'd300, {16'd200, 16'd166}, 1'b0, 16);        drain();

    repeat (5) @(negedge clk);
    check("lat_q_empty", 64'(lat_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
